// File: rtl/h80cpu_io_port.sv
// h80 CPU I/O-space slave: toggle-handshake bus front end on clk plus an
// 8N1 UART transmitter on sysclk, joined by toggle synchronizers.
`timescale 1ns/1ps
module h80cpu_io_port #(
  parameter int SYSCLK_FREQ = 27000000,
  parameter int BAUD        = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [2:0]  cmd,
  input  logic        run,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        done,
  input  logic        sysclk,
  output logic        uart_txp
);

  localparam int BIT_CYCLES = SYSCLK_FREQ / BAUD;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // clk domain
  logic       req_tgl_r;
  logic       ack_meta_r;
  logic       ack_sync_r;
  logic [7:0] hold_byte_r;

  logic pending_s;
  logic sel_s;
  logic is_read_s;
  logic is_write_s;
  logic tx_busy_s;
  logic accept_wr_s;
  logic complete_s;

  // sysclk domain
  logic                rst_meta_r;
  logic                rst_sync_r;
  logic                req_meta_r;
  logic                req_sync_r;
  logic                ack_tgl_r;
  tx_state_t           state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          idx_r;
  logic [7:0]          shift_r;

  tx_state_t           state_nxt_s;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [2:0]          idx_nxt_s;
  logic [7:0]          shift_nxt_s;
  logic                ack_nxt_s;
  logic                txp_nxt_s;
  logic                bit_end_s;

  logic unused_bits_s;
  assign unused_bits_s = ^{wr_data[15:8], addr[0]};

  // Bus request decode and completion decision
  always_comb begin
    pending_s  = (run != done);
    sel_s      = (addr[15:1] == 15'd0);
    is_read_s  = 1'b0;
    is_write_s = 1'b0;
    case (cmd)
      3'd0, 3'd1: is_read_s  = 1'b1;
      3'd2, 3'd3: is_write_s = 1'b1;
      default: begin
        is_read_s  = 1'b0;
        is_write_s = 1'b0;
      end
    endcase
    tx_busy_s   = (req_tgl_r != ack_sync_r);
    accept_wr_s = pending_s && sel_s && is_write_s && !tx_busy_s;
    // A UART write stalls while the previous byte is still in flight
    if (pending_s && sel_s && is_write_s) begin
      complete_s = !tx_busy_s;
    end else begin
      complete_s = pending_s;
    end
  end

  // Bus-side registers: handshake, read data, holding byte, ack synchronizer
  always_ff @(posedge clk) begin
    if (reset) begin
      done        <= 1'b0;
      rd_data     <= 16'd0;
      req_tgl_r   <= 1'b0;
      hold_byte_r <= 8'd0;
      ack_meta_r  <= 1'b0;
      ack_sync_r  <= 1'b0;
    end else begin
      ack_meta_r <= ack_tgl_r;
      ack_sync_r <= ack_meta_r;
      if (accept_wr_s) begin
        hold_byte_r <= wr_data[7:0];
        req_tgl_r   <= ~req_tgl_r;
      end
      if (complete_s) begin
        done <= ~done;
        if (is_read_s) begin
          rd_data <= sel_s ? {15'd0, tx_busy_s} : 16'd0;
        end
      end
    end
  end

  // Reset synchronizer into sysclk
  always_ff @(posedge sysclk) begin
    rst_meta_r <= reset;
    rst_sync_r <= rst_meta_r;
  end

  // Serializer next-state; line level is derived from the next state
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    ack_nxt_s   = ack_tgl_r;
    bit_end_s   = (cnt_r == BIT_LAST);
    case (state_r)
      S_IDLE: begin
        cnt_nxt_s = CNT_ZERO;
        // hold_byte_r is stable while req and ack differ
        if (req_sync_r != ack_tgl_r) begin
          state_nxt_s = S_START;
          shift_nxt_s = hold_byte_r;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_nxt_s = S_DATA;
          cnt_nxt_s   = CNT_ZERO;
          idx_nxt_s   = 3'd0;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_nxt_s   = CNT_ZERO;
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (idx_r == 3'd7) begin
            state_nxt_s = S_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = CNT_ZERO;
          ack_nxt_s   = ~ack_tgl_r;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
    case (state_nxt_s)
      S_START: txp_nxt_s = 1'b0;
      S_DATA:  txp_nxt_s = shift_nxt_s[0];
      default: txp_nxt_s = 1'b1;
    endcase
  end

  // Serializer state, request synchronizer and registered line output
  always_ff @(posedge sysclk) begin
    if (rst_sync_r) begin
      req_meta_r <= 1'b0;
      req_sync_r <= 1'b0;
      state_r    <= S_IDLE;
      cnt_r      <= CNT_ZERO;
      idx_r      <= 3'd0;
      shift_r    <= 8'd0;
      ack_tgl_r  <= 1'b0;
      uart_txp   <= 1'b1;
    end else begin
      req_meta_r <= req_tgl_r;
      req_sync_r <= req_meta_r;
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      idx_r      <= idx_nxt_s;
      shift_r    <= shift_nxt_s;
      ack_tgl_r  <= ack_nxt_s;
      uart_txp   <= txp_nxt_s;
    end
  end

endmodule

// File: tb/tb_h80cpu_io_port.sv
// Directed bench for h80cpu_io_port: bus handshake, status reads, UART frame
// shape and timing, stall on back-to-back writes, unmapped access, mid-frame reset.
`timescale 1ns/1ps
module tb_h80cpu_io_port;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [2:0]  cmd;
  logic        run;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        done;
  logic        sysclk;
  logic        uart_txp;

  int checks   = 0;
  int failures = 0;

  localparam int BITC = 234;

  h80cpu_io_port dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .cmd      (cmd),
    .run      (run),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .done     (done),
    .sysclk   (sysclk),
    .uart_txp (uart_txp)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  initial sysclk = 1'b0;
  always #3.7 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] w,
                        output int cyc);
    @(negedge clk);
    cmd = c; addr = a; wr_data = w; run = ~run;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== run && cyc < 2000);
  endtask

  // Waits for a start bit, then records one full 10-bit frame sample by sample.
  task automatic capture(output logic [9:0] bits, output int low_run, output int bad,
                         output logic to);
    logic s [0:10*BITC-1];
    int n;
    bits = 10'd0; low_run = 0; bad = 0; to = 1'b0;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (uart_txp !== 1'b0 && n < 20000);
    if (uart_txp !== 1'b0) begin
      to = 1'b1;
    end else begin
      s[0] = uart_txp;
      for (int i = 1; i < 10*BITC; i++) begin
        @(negedge sysclk);
        s[i] = uart_txp;
      end
      for (int k = 0; k < 10; k++) bits[k] = s[k*BITC + BITC/2];
      low_run = 10*BITC;
      for (int i = 10*BITC - 1; i >= 0; i--) if (s[i] === 1'b1) low_run = i;
      for (int i = 0; i < 10*BITC; i++) if (s[i] !== bits[i/BITC]) bad++;
    end
  endtask

  task automatic count_low(input int ncyc, output int lows);
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge sysclk);
      if (uart_txp !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [9:0] b1, b2;
    int lr1, lr2, bad1, bad2, cyc, cyc2, lows, n;
    logic to1, to2;

    reset = 1'b1; run = 1'b0; cmd = 3'd0; addr = 16'd0; wr_data = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_done", done, 1'b0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_txp", uart_txp, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_txp", uart_txp, 1'b1);

    // Write 'H' (0x48), status busy, unmapped read clears rd_data
    fork
      capture(b1, lr1, bad1, to1);
      begin
        bus_op(3'd3, 16'h0000, 16'h0048, cyc);
        check("wr_latency", cyc, 1);
        check("wr_done", done, 1'b1);
        bus_op(3'd1, 16'h0000, 16'h0000, cyc);
        check("status_busy", rd_data, 16'h0001);
        bus_op(3'd1, 16'h0010, 16'h0000, cyc);
        check("unmap_rd_latency", cyc, 1);
        check("unmap_rd_data", rd_data, 16'h0000);
      end
    join
    check("f1_timeout", to1, 1'b0);
    check("f1_bits", b1, {1'b1, 8'h48, 1'b0});
    check("f1_low_run", lr1, 4*BITC);
    check("f1_bad_cycles", bad1, 0);
    repeat (10) @(negedge clk);
    bus_op(3'd1, 16'h0000, 16'h0000, cyc);
    check("status_idle", rd_data, 16'h0000);

    // Back-to-back 'H' then 'e'
    fork
      begin
        capture(b1, lr1, bad1, to1);
        capture(b2, lr2, bad2, to2);
      end
      begin
        bus_op(3'd3, 16'h0000, 16'h0048, cyc);
        bus_op(3'd3, 16'h0001, 16'h7765, cyc2);
      end
    join
    check("b2b_first_latency", cyc, 1);
    check("b2b_second_stalled", (cyc2 >= 800) && (cyc2 < 2000), 1'b1);
    check("b2b_second_done", done, run);
    check("b2b_f1", {to1, b1}, {1'b0, 1'b1, 8'h48, 1'b0});
    check("b2b_f2", {to2, b2}, {1'b0, 1'b1, 8'h65, 1'b0});
    check("b2b_bad_cycles", bad1 + bad2, 0);

    // Unmapped write and no-op command while idle
    repeat (10) @(negedge clk);
    bus_op(3'd2, 16'h0010, 16'h0055, cyc);
    check("unmap_wr_latency", cyc, 1);
    bus_op(3'd6, 16'h0000, 16'h0055, cyc);
    check("noop_latency", cyc, 1);
    count_low(600, lows);
    check("unmap_line_idle", lows, 0);
    bus_op(3'd0, 16'h0000, 16'h0000, cyc);
    check("unmap_not_busy", rd_data, 16'h0000);

    // Reset during D3 of 0xA5 (D3 = 0)
    bus_op(3'd3, 16'h0000, 16'h00A5, cyc);
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (uart_txp !== 1'b0 && n < 100);
    check("a5_start", uart_txp, 1'b0);
    repeat (4*BITC + BITC/2) @(negedge sysclk);
    check("a5_d3", uart_txp, 1'b0);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    n = 0;
    do begin
      @(posedge sysclk);
      #1;
      n++;
    end while (uart_txp !== 1'b1 && n < 10);
    check("rst_abort_within_3", n <= 3, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_mid_done", done, 1'b0);
    count_low(3000, lows);
    check("no_resend", lows, 0);
    bus_op(3'd1, 16'h0000, 16'h0000, cyc);
    check("post_rst_idle", rd_data, 16'h0000);
    fork
      capture(b1, lr1, bad1, to1);
      bus_op(3'd3, 16'h0000, 16'h006B, cyc);
    join
    check("post_rst_wr_latency", cyc, 1);
    check("post_rst_frame", {to1, b1}, {1'b0, 1'b1, 8'h6B, 1'b0});
    check("post_rst_bad_cycles", bad1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
